// File: rtl/ds_pkg.sv
// Shared definitions for the 2x2 downsample sequencer: state encoding,
// block tap offsets and derived address-width helper.
package ds_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        FWAIT = 3'd2,
        AVG   = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } ds_state_t;

    localparam int NUM_TAPS = 4;

    // Raster offset of tap k inside a 2x2 block: TL, TR, BL, BR.
    function automatic int ds_off(input int k, input int w);
        case (k)
            0:       return 0;
            1:       return 1;
            2:       return w;
            default: return w + 1;
        endcase
    endfunction

    function automatic int ds_aw(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ds_addr_gen.sv
// Source/destination address generator for the downsampler. Walks the output
// raster with counters and adders only; clears itself after the last pixel.
module ds_addr_gen
    import ds_pkg::*;
#(
    parameter int SRC_WIDTH  = 56,
    parameter int SRC_HEIGHT = 56,
    parameter int SRC_AW     = ds_aw(SRC_WIDTH * SRC_HEIGHT),
    parameter int DST_AW     = ds_aw((SRC_WIDTH / 2) * (SRC_HEIGHT / 2))
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_fetch,
    input  logic              i_pix_adv,
    output logic [SRC_AW-1:0] o_src_addr,
    output logic [DST_AW-1:0] o_dst_addr,
    output logic              o_k_last,
    output logic              o_last_pixel
);

    localparam int OUT_W = SRC_WIDTH / 2;
    localparam int NPIX  = OUT_W * (SRC_HEIGHT / 2);
    localparam int OXW   = ds_aw(OUT_W);

    logic [OXW-1:0]    r_ox;
    logic [SRC_AW-1:0] r_row_base;
    logic [1:0]        r_k;
    logic [DST_AW-1:0] r_out_idx;
    logic [SRC_AW-1:0] w_off;

    always_comb begin
        w_off = '0;
        case (r_k)
            2'd0:    w_off = SRC_AW'(ds_off(0, SRC_WIDTH));
            2'd1:    w_off = SRC_AW'(ds_off(1, SRC_WIDTH));
            2'd2:    w_off = SRC_AW'(ds_off(2, SRC_WIDTH));
            default: w_off = SRC_AW'(ds_off(3, SRC_WIDTH));
        endcase
    end

    assign o_src_addr   = r_row_base + SRC_AW'({r_ox, 1'b0}) + w_off;
    assign o_dst_addr   = r_out_idx;
    assign o_k_last     = (r_k == 2'd3);
    assign o_last_pixel = (r_out_idx == DST_AW'(NPIX - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ox       <= '0;
            r_row_base <= '0;
            r_k        <= '0;
            r_out_idx  <= '0;
        end else begin
            if (i_fetch)
                r_k <= r_k + 2'd1;
            if (i_pix_adv) begin
                // Returning to zero leaves the next frame ready to start at address 0.
                if (o_last_pixel) begin
                    r_ox       <= '0;
                    r_row_base <= '0;
                    r_out_idx  <= '0;
                end else begin
                    r_out_idx <= r_out_idx + DST_AW'(1);
                    if (r_ox == OXW'(OUT_W - 1)) begin
                        r_ox       <= '0;
                        r_row_base <= r_row_base + SRC_AW'(2 * SRC_WIDTH);
                    end else begin
                        r_ox <= r_ox + OXW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/pixel_downsample_ctrl.sv
// 2x2 block-average downsample sequencer: fetches four source pixels, feeds the
// external averager, writes the result. Build option DS_BINARIZE_EN thresholds the output.
module pixel_downsample_ctrl
    import ds_pkg::*;
#(
    parameter int SRC_WIDTH  = 56,
    parameter int SRC_HEIGHT = 56,
    parameter int RESOLUTION = 8,
    parameter int THRESH     = 128,
    parameter int SRC_AW     = ds_aw(SRC_WIDTH * SRC_HEIGHT),
    parameter int DST_AW     = ds_aw((SRC_WIDTH / 2) * (SRC_HEIGHT / 2))
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  src_rd_en,
    output logic [SRC_AW-1:0]     src_addr,
    input  logic [RESOLUTION-1:0] src_data,
    output logic                  avg_en,
    output logic [RESOLUTION-1:0] avg_p0,
    output logic [RESOLUTION-1:0] avg_p1,
    output logic [RESOLUTION-1:0] avg_p2,
    output logic [RESOLUTION-1:0] avg_p3,
    input  logic [RESOLUTION-1:0] avg_result,
    output logic                  dst_wr_en,
    output logic [DST_AW-1:0]     dst_addr,
    output logic [RESOLUTION-1:0] dst_data
);

    if ((SRC_WIDTH % 2) != 0 || (SRC_HEIGHT % 2) != 0 || THRESH >= (1 << RESOLUTION)) begin : g_bad_cfg
        $error("pixel_downsample_ctrl: dimensions must be even and THRESH must fit RESOLUTION");
    end

    ds_state_t r_state, w_next;

    logic [2:0][RESOLUTION-1:0] r_pix;
    logic [3:0][RESOLUTION-1:0] r_avg_p;
    logic                       r_cap_vld;
    logic [RESOLUTION-1:0]      r_dst_data;
    logic [RESOLUTION-1:0]      w_avg_val;
    logic                       w_k_last;
    logic                       w_last_pixel;

    ds_addr_gen #(
        .SRC_WIDTH (SRC_WIDTH),
        .SRC_HEIGHT(SRC_HEIGHT),
        .SRC_AW    (SRC_AW),
        .DST_AW    (DST_AW)
    ) u_addr_gen (
        .clk         (clk),
        .reset       (reset),
        .i_fetch     (r_state == FETCH),
        .i_pix_adv   (r_state == WRITE),
        .o_src_addr  (src_addr),
        .o_dst_addr  (dst_addr),
        .o_k_last    (w_k_last),
        .o_last_pixel(w_last_pixel)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = FETCH;
            FETCH:   if (w_k_last) w_next = FWAIT;
            FWAIT:   w_next = AVG;
            AVG:     w_next = WRITE;
            WRITE:   w_next = w_last_pixel ? DONE : FETCH;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    assign busy      = (r_state == FETCH) || (r_state == FWAIT) ||
                       (r_state == AVG)   || (r_state == WRITE);
    assign done      = (r_state == DONE);
    assign src_rd_en = (r_state == FETCH);
    assign avg_en    = (r_state == AVG);
    assign dst_wr_en = (r_state == WRITE);

`ifdef DS_BINARIZE_EN
    assign w_avg_val = (avg_result >= RESOLUTION'(THRESH)) ? '1 : '0;
`else
    assign w_avg_val = avg_result;
`endif

    // Reads return one cycle late; p0..p2 shift in, p3 lands straight in the averager regs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cap_vld  <= 1'b0;
            r_pix      <= '0;
            r_avg_p    <= '0;
            r_dst_data <= '0;
        end else begin
            r_cap_vld <= src_rd_en;
            if (r_cap_vld)
                r_pix <= {r_pix[1:0], src_data};
            if (r_state == FWAIT)
                r_avg_p <= {src_data, r_pix[0], r_pix[1], r_pix[2]};
            if (r_state == AVG)
                r_dst_data <= w_avg_val;
        end
    end

    assign avg_p0   = r_avg_p[0];
    assign avg_p1   = r_avg_p[1];
    assign avg_p2   = r_avg_p[2];
    assign avg_p3   = r_avg_p[3];
    assign dst_data = r_dst_data;

endmodule

// File: tb/tb_pixel_downsample_ctrl.sv
// Bench for pixel_downsample_ctrl: a 4x4 and a 56x56 instance driven from frame
// memories, checked against a raster-order block-average model.
module tb_pixel_downsample_ctrl;

    localparam int AW_ = 4, AH = 4, BW = 56, BH = 56;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start_a, start_b;

    logic       a_busy, a_done, a_rd, a_aen, a_wr;
    logic [3:0] a_saddr;
    logic [1:0] a_daddr;
    logic [7:0] a_sdata = '0, a_p0, a_p1, a_p2, a_p3, a_res, a_ddata;

    logic        b_busy, b_done, b_rd, b_aen, b_wr;
    logic [11:0] b_saddr;
    logic [9:0]  b_daddr;
    logic [7:0]  b_sdata = '0, b_p0, b_p1, b_p2, b_p3, b_res, b_ddata;

    int mem_a [AW_*AH];
    int mem_b [BW*BH];

    int n_tests = 0, n_fail = 0;

    pixel_downsample_ctrl #(.SRC_WIDTH(AW_), .SRC_HEIGHT(AH), .RESOLUTION(8), .THRESH(128)) u_a (
        .clk(clk), .reset(reset), .start(start_a), .busy(a_busy), .done(a_done),
        .src_rd_en(a_rd), .src_addr(a_saddr), .src_data(a_sdata),
        .avg_en(a_aen), .avg_p0(a_p0), .avg_p1(a_p1), .avg_p2(a_p2), .avg_p3(a_p3),
        .avg_result(a_res), .dst_wr_en(a_wr), .dst_addr(a_daddr), .dst_data(a_ddata));

    pixel_downsample_ctrl #(.SRC_WIDTH(BW), .SRC_HEIGHT(BH), .RESOLUTION(8), .THRESH(128)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .busy(b_busy), .done(b_done),
        .src_rd_en(b_rd), .src_addr(b_saddr), .src_data(b_sdata),
        .avg_en(b_aen), .avg_p0(b_p0), .avg_p1(b_p1), .avg_p2(b_p2), .avg_p3(b_p3),
        .avg_result(b_res), .dst_wr_en(b_wr), .dst_addr(b_daddr), .dst_data(b_ddata));

    // Frame buffers with a one-cycle synchronous read, and the external averager.
    always @(posedge clk) if (a_rd) a_sdata <= 8'(mem_a[a_saddr]);
    always @(posedge clk) if (b_rd) b_sdata <= 8'(mem_b[b_saddr]);
    assign a_res = 8'((10'(a_p0) + 10'(a_p1) + 10'(a_p2) + 10'(a_p3)) >> 2);
    assign b_res = 8'((10'(b_p0) + 10'(b_p1) + 10'(b_p2) + 10'(b_p3)) >> 2);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    int  rq_a[$], wa_a[$], wd_a[$], rq_b[$], wa_b[$], wd_b[$];
    int  done_a = 0, done_b = 0;
    logic pav_a = 1'b0, pav_b = 1'b0;

    always @(negedge clk) begin
        if (a_rd) rq_a.push_back(int'(a_saddr));
        if (a_wr) begin wa_a.push_back(int'(a_daddr)); wd_a.push_back(int'(a_ddata)); end
        if (a_done) begin done_a <= done_a + 1; chk("a_busy_at_done", 32'(a_busy), 0); end
        chk("a_one_strobe", 32'($countones({a_rd, a_aen, a_wr}) <= 1), 1);
        chk("a_wr_follows_avg", 32'(a_wr), 32'(pav_a));
        pav_a <= a_aen;
    end

    always @(negedge clk) begin
        if (b_rd) rq_b.push_back(int'(b_saddr));
        if (b_wr) begin wa_b.push_back(int'(b_daddr)); wd_b.push_back(int'(b_ddata)); end
        if (b_done) begin done_b <= done_b + 1; chk("b_busy_at_done", 32'(b_busy), 0); end
        chk("b_one_strobe", 32'($countones({b_rd, b_aen, b_wr}) <= 1), 1);
        chk("b_wr_follows_avg", 32'(b_wr), 32'(pav_b));
        pav_b <= b_aen;
    end

    function automatic int bin(input int v);
`ifdef DS_BINARIZE_EN
        return (v >= 128) ? 255 : 0;
`else
        return v;
`endif
    endfunction

    function automatic int pix(input bit b, input int i);
        return b ? mem_b[i] : mem_a[i];
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_obs(input bit b);
        if (b) begin rq_b.delete(); wa_b.delete(); wd_b.delete(); done_b = 0; end
        else   begin rq_a.delete(); wa_a.delete(); wd_a.delete(); done_a = 0; end
    endtask

    // Pulse start, return cycles from the first FETCH cycle to the done cycle.
    task automatic run_frame(input bit b, output int lat);
        clear_obs(b);
        if (b) start_b = 1'b1; else start_a = 1'b1;
        tick();
        start_a = 1'b0; start_b = 1'b0;
        chk("first_fetch_busy", 32'(b ? b_busy : a_busy), 1);
        chk("first_fetch_rd", 32'(b ? b_rd : a_rd), 1);
        lat = 0;
        while (!(b ? b_done : a_done) && lat < 10000) begin tick(); lat++; end
        chk("done_within_budget", 32'(lat < 10000), 1);
        tick(); tick();
    endtask

    task automatic check_frame(input bit b);
        int rq[$], wa[$], wd[$];
        int w, h, no, o, base, a, sum, dn;
        if (b) begin rq = rq_b; wa = wa_b; wd = wd_b; dn = done_b; w = BW; h = BH; end
        else   begin rq = rq_a; wa = wa_a; wd = wd_a; dn = done_a; w = AW_; h = AH; end
        no = (w / 2) * (h / 2);
        chk("rd_count", rq.size(), 4 * no);
        chk("wr_count", wa.size(), no);
        chk("done_count", dn, 1);
        for (int oy = 0; oy < h / 2; oy++)
            for (int ox = 0; ox < w / 2; ox++) begin
                o    = oy * (w / 2) + ox;
                base = 2 * oy * w + 2 * ox;
                sum  = 0;
                for (int k = 0; k < 4; k++) begin
                    a = base + (k / 2) * w + (k % 2);
                    sum += pix(b, a);
                    if (4 * o + k < rq.size()) chk("rd_addr", rq[4*o+k], a);
                end
                if (o < wa.size()) begin
                    chk("wr_addr", wa[o], o);
                    chk("wr_data", wd[o], bin(sum / 4));
                end
            end
    endtask

    task automatic check_zero(input bit b);
        chk("rst_busy",  32'(b ? b_busy : a_busy), 0);
        chk("rst_done",  32'(b ? b_done : a_done), 0);
        chk("rst_rd",    32'(b ? b_rd : a_rd), 0);
        chk("rst_aen",   32'(b ? b_aen : a_aen), 0);
        chk("rst_wr",    32'(b ? b_wr : a_wr), 0);
        chk("rst_saddr", b ? 32'(b_saddr) : 32'(a_saddr), 0);
        chk("rst_daddr", b ? 32'(b_daddr) : 32'(a_daddr), 0);
        chk("rst_ddata", 32'(b ? b_ddata : a_ddata), 0);
        chk("rst_p0",    32'(b ? b_p0 : a_p0), 0);
        chk("rst_p1",    32'(b ? b_p1 : a_p1), 0);
        chk("rst_p2",    32'(b ? b_p2 : a_p2), 0);
        chk("rst_p3",    32'(b ? b_p3 : a_p3), 0);
    endtask

    initial begin
        int lat, n;
        int exp_rd[16] = '{0,1,4,5, 2,3,6,7, 8,9,12,13, 10,11,14,15};
        int exp_wd[4]  = '{2,4,10,12};

        reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        check_zero(0);
        check_zero(1);

        // 4x4 ramp image
        for (int i = 0; i < AW_*AH; i++) mem_a[i] = i;
        run_frame(0, lat);
        chk("a_done_latency", lat, 7 * (AW_/2) * (AH/2));
        check_frame(0);
        for (int i = 0; i < 16; i++) if (i < rq_a.size()) chk("a_rd_table", rq_a[i], exp_rd[i]);
        for (int i = 0; i < 4; i++) if (i < wd_a.size()) chk("a_wd_table", wd_a[i], bin(exp_wd[i]));

        // start held high through the whole frame and the DONE cycle
        clear_obs(0);
        start_a = 1'b1;
        n = 0;
        while (!a_done && n < 200) begin tick(); n++; end
        chk("spam_done_seen", 32'(n < 200), 1);
        tick();
        start_a = 1'b0;
        repeat (20) tick();
        chk("spam_idle", 32'(a_busy), 0);
        check_frame(0);

        // random image at full size
        for (int i = 0; i < BW*BH; i++) mem_b[i] = int'($urandom_range(0, 255));
        run_frame(1, lat);
        chk("b_done_latency", lat, 7 * (BW/2) * (BH/2));
        check_frame(1);

        // all-255 image
        for (int i = 0; i < BW*BH; i++) mem_b[i] = 255;
        run_frame(1, lat);
        check_frame(1);
        if (wa_b.size() > 0) chk("b_last_daddr", wa_b[wa_b.size()-1], 783);

        // reset during the 10th output write, then a fresh frame
        for (int i = 0; i < BW*BH; i++) mem_b[i] = int'($urandom_range(0, 255));
        clear_obs(1);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 0;
        while (!(b_wr && b_daddr == 10'd9) && n < 2000) begin tick(); n++; end
        chk("abort_reach_px10", 32'(n < 2000), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_zero(1);
        repeat (30) tick();
        chk("abort_no_done", done_b, 0);
        chk("abort_wr_count", wa_b.size(), 10);
        run_frame(1, lat);
        check_frame(1);

`ifdef DS_BINARIZE_EN
        for (int i = 0; i < AW_*AH; i++) mem_a[i] = int'($urandom_range(0, 255));
        mem_a[0] = 127; mem_a[1] = 127; mem_a[4] = 127; mem_a[5] = 127;
        mem_a[2] = 128; mem_a[3] = 128; mem_a[6] = 128; mem_a[7] = 128;
        run_frame(0, lat);
        if (wd_a.size() > 1) begin
            chk("bin_127", wd_a[0], 0);
            chk("bin_128", wd_a[1], 255);
        end
        check_frame(0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
